// File: rtl/shift_seq_if.sv
// shift_seq_if: request/result bundle for the multi-cycle shifter.
// The master drives the request; the slave (shift_seq) returns busy/done/out.
interface shift_seq_if;
    logic        start;
    logic [15:0] in;
    logic [1:0]  op;
    logic [3:0]  cnt;
    logic        busy;
    logic        done;
    logic [15:0] out;

    modport master (output start, output in, output op, output cnt,
                    input  busy,  input  done, input  out);
    modport slave  (input  start, input  in,  input  op,  input  cnt,
                    output busy,  output done, output out);
endinterface

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle 16-bit rotate/shift unit moving the word one bit per cycle.
// Optional macro SHIFT_SEQ_FAST8_EN: an amount with cnt[3] set takes an 8-bit first step.
module shift_seq #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    shift_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_SRL = 2'b11
    } op_e;

    state_e             state_r, state_next_s;
    op_e                op_r, op_next_s;
    logic [3:0]         rem_r, rem_next_s;
    logic [WIDTH-1:0]   work_r, work_next_s;
    logic [WIDTH-1:0]   out_r;
    logic               busy_r;
    logic               done_r;

    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] w, input op_e o);
        logic [WIDTH-1:0] r;
        case (o)
            OP_ROL:  r = {w[WIDTH-2:0], w[WIDTH-1]};
            OP_SLL:  r = {w[WIDTH-2:0], 1'b0};
            OP_SRA:  r = {w[WIDTH-1], w[WIDTH-1:1]};
            OP_SRL:  r = {1'b0, w[WIDTH-1:1]};
            default: r = w;
        endcase
        return r;
    endfunction

`ifdef SHIFT_SEQ_FAST8_EN
    function automatic logic [WIDTH-1:0] step8(input logic [WIDTH-1:0] w, input op_e o);
        logic [WIDTH-1:0] r;
        case (o)
            OP_ROL:  r = {w[WIDTH-9:0], w[WIDTH-1:WIDTH-8]};
            OP_SLL:  r = {w[WIDTH-9:0], 8'h00};
            OP_SRA:  r = {{8{w[WIDTH-1]}}, w[WIDTH-1:8]};
            OP_SRL:  r = {8'h00, w[WIDTH-1:8]};
            default: r = w;
        endcase
        return r;
    endfunction
`endif

    // Next-state, working word and remaining-count logic.
    always_comb begin
        state_next_s = state_r;
        op_next_s    = op_r;
        rem_next_s   = rem_r;
        work_next_s  = work_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    work_next_s = bus.in;
                    op_next_s   = op_e'(bus.op);
                    rem_next_s  = bus.cnt;
                    if (bus.cnt != 4'd0) begin
                        state_next_s = SHIFT;
                    end else begin
                        state_next_s = DONE;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
`ifdef SHIFT_SEQ_FAST8_EN
                // Only the first SHIFT cycle can see rem[3] set.
                if (rem_r[3]) begin
                    work_next_s = step8(work_r, op_r);
                    rem_next_s  = {1'b0, rem_r[2:0]};
                end else begin
                    work_next_s = step1(work_r, op_r);
                    rem_next_s  = rem_r - 4'd1;
                end
`else
                work_next_s = step1(work_r, op_r);
                rem_next_s  = rem_r - 4'd1;
`endif
                if (rem_next_s == 4'd0) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            op_r    <= OP_ROL;
            rem_r   <= 4'd0;
            work_r  <= 16'h0000;
            out_r   <= 16'h0000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            op_r    <= op_next_s;
            rem_r   <= rem_next_s;
            work_r  <= work_next_s;
            busy_r  <= (state_next_s == SHIFT);
            done_r  <= (state_next_s == DONE);
            // Result is published on entry to DONE and held otherwise.
            if (state_next_s == DONE) begin
                out_r <= work_next_s;
            end else begin
                out_r <= out_r;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.out  = out_r;

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed-vector bench for shift_seq with hand-computed results.
// Honours SHIFT_SEQ_FAST8_EN when computing the expected done latency.
module tb_shift_seq;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [15:0] last_out;

    shift_seq_if bus ();

    shift_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] c);
`ifdef SHIFT_SEQ_FAST8_EN
        return int'(c[3]) + int'(c[2:0]) + 1;
`else
        return int'(c) + 1;
`endif
    endfunction

    // Counts negedges until done (bounded); busy cycles and out stability tracked.
    task automatic wait_done(output int cyc, output int busy_cyc, output bit held_ok);
        cyc = 0;
        busy_cyc = 0;
        held_ok = 1'b1;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done) break;
            if (bus.busy) busy_cyc++;
            if (bus.out !== last_out) held_ok = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [1:0] o,
                          input logic [3:0] c, input logic [15:0] exp);
        int cyc, busy_cyc;
        bit held_ok;
        @(negedge clk);
        bus.start = 1'b1; bus.in = a; bus.op = o; bus.cnt = c;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.in = 16'hDEAD; bus.op = 2'b11; bus.cnt = 4'hF;
        wait_done(cyc, busy_cyc, held_ok);
        check({tag, "_lat"}, cyc, exp_lat(c));
        check({tag, "_out"}, bus.out, exp);
        check({tag, "_busy"}, busy_cyc, exp_lat(c) - 1);
        check({tag, "_hold"}, {31'd0, held_ok}, 32'd1);
        last_out = exp;
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_out_held"}, bus.out, exp);
    endtask

    initial begin
        int  cyc, busy_cyc;
        bit  held_ok;
        bit  saw_done;
        vectors = 0;
        miscompares = 0;
        last_out = 16'h0000;
        bus.start = 1'b0; bus.in = 16'h0000; bus.op = 2'b00; bus.cnt = 4'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out", bus.out, 16'h0000);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;

        run_op("t1_rol1",   16'h8001, 2'b00, 4'd1,  16'h0003);
        run_op("t2_sra4n",  16'h8000, 2'b10, 4'd4,  16'hF800);
        run_op("t2_sra4p",  16'h7000, 2'b10, 4'd4,  16'h0700);
        run_op("t3_srl15",  16'hFFFF, 2'b11, 4'd15, 16'h0001);
        run_op("t4_sll0",   16'h1234, 2'b01, 4'd0,  16'h1234);
        run_op("t4_sll8",   16'h00FF, 2'b01, 4'd8,  16'hFF00);
        run_op("b_sra15",   16'h8000, 2'b10, 4'd15, 16'hFFFF);
        run_op("b_srl15",   16'h8000, 2'b11, 4'd15, 16'h0001);
        run_op("b_rol8",    16'h1234, 2'b00, 4'd8,  16'h3412);
        run_op("b_rol12",   16'h1234, 2'b00, 4'd12, 16'h4123);

        // Start held high with changing operands while busy.
        @(negedge clk);
        bus.start = 1'b1; bus.in = 16'h8001; bus.op = 2'b00; bus.cnt = 4'd3;
        @(posedge clk);
        #1;
        bus.in = 16'hFFFF; bus.op = 2'b11; bus.cnt = 4'd1;
        wait_done(cyc, busy_cyc, held_ok);
        check("t5_lat", cyc, exp_lat(4'd3));
        check("t5_out", bus.out, 16'h000C);
        check("t5_hold", {31'd0, held_ok}, 32'd1);
        last_out = 16'h000C;
        @(negedge clk);
        check("t5_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("t5_idle_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        check("t5_reaccept", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        wait_done(cyc, busy_cyc, held_ok);
        check("t5b_lat", cyc, 32'd1);
        check("t5b_out", bus.out, 16'h7FFF);
        last_out = 16'h7FFF;

        // Reset in the middle of a cnt=10 operation.
        @(negedge clk);
        bus.start = 1'b1; bus.in = 16'h00FF; bus.op = 2'b00; bus.cnt = 4'd10;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_out", bus.out, 16'h0000);
        check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("t6_rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        check("t6_no_done", {31'd0, saw_done}, 32'd0);
        last_out = 16'h0000;
        run_op("t6_restart", 16'h00FF, 2'b00, 4'd10, 16'hFC03);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
